// File: rtl/crc_frame_serializer_if.sv
// crc_frame_serializer_if: byte-stream input and serial bit-link output of the
// CRC frame serializer, grouped so the framing stage and its neighbours share one bundle.
interface crc_frame_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              tx_bit;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    modport master (
        output s_data, s_valid, s_last, tx_ready,
        input  s_ready, tx_bit, tx_valid, tx_last
    );

    modport slave (
        input  s_data, s_valid, s_last, tx_ready,
        output s_ready, tx_bit, tx_valid, tx_last
    );
endinterface

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: transmit-side framing stage. Serialises each byte frame
// MSB-first, steers an external CCITT serial CRC engine over the data bits, then
// appends the 16-bit CRC and an inter-frame gap.
// Optional feature: define CRC_FRAME_INVERT_EN to append the ones-complement of the CRC.
module crc_frame_serializer #(
    parameter int DATA_W     = 8,
    parameter int CRC_W      = 16,
    parameter int IFG_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    crc_frame_serializer_if.slave bus,
    output logic                  o_crc_enable,
    output logic                  o_crc_init,
    output logic                  o_crc_data,
    input  logic [CRC_W-1:0]      i_crc_value,
    output logic                  o_busy
);
    localparam int MAX_DC  = (CRC_W > DATA_W) ? CRC_W : DATA_W;
    localparam int MAX_ALL = (IFG_CYCLES > MAX_DC) ? IFG_CYCLES : MAX_DC;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DATA,
        ST_CRC_LOAD,
        ST_CRC,
        ST_GAP
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [DATA_W-1:0] r_sreg;
    logic [DATA_W-1:0] w_sregNext;
    logic [CRC_W-1:0]  r_crcSreg;
    logic [CRC_W-1:0]  w_crcSregNext;
    logic [CRC_W-1:0]  w_crcCapture;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;
    logic              r_byteVld;
    logic              w_byteVldNext;
    logic              r_lastFlag;
    logic              w_lastFlagNext;
    logic              w_sReady;
    logic              w_txBit;
    logic              w_txValid;
    logic              w_txLast;
    logic              w_crcEnable;
    logic              w_crcInit;
    logic              w_crcData;

`ifdef CRC_FRAME_INVERT_EN
    assign w_crcCapture = ~i_crc_value;
`else
    assign w_crcCapture = i_crc_value;
`endif

    // State and datapath registers; synchronous reset drops any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sreg     <= '0;
            r_crcSreg  <= '0;
            r_cnt      <= '0;
            r_byteVld  <= 1'b0;
            r_lastFlag <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_sreg     <= w_sregNext;
            r_crcSreg  <= w_crcSregNext;
            r_cnt      <= w_cntNext;
            r_byteVld  <= w_byteVldNext;
            r_lastFlag <= w_lastFlagNext;
        end
    end

    // Next-state, shift/count updates and handshake outputs for the framing sequence
    always_comb begin
        w_stateNext    = r_state;
        w_sregNext     = r_sreg;
        w_crcSregNext  = r_crcSreg;
        w_cntNext      = r_cnt;
        w_byteVldNext  = r_byteVld;
        w_lastFlagNext = r_lastFlag;
        w_sReady       = 1'b0;
        w_txBit        = 1'b0;
        w_txValid      = 1'b0;
        w_txLast       = 1'b0;
        w_crcEnable    = 1'b0;
        w_crcInit      = 1'b0;
        w_crcData      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sReady = 1'b1;
                if (bus.s_valid) begin
                    w_sregNext     = bus.s_data;
                    w_lastFlagNext = bus.s_last;
                    w_cntNext      = '0;
                    w_byteVldNext  = 1'b1;
                    w_stateNext    = ST_INIT;
                end
            end

            ST_INIT: begin
                w_crcEnable = 1'b1;
                w_crcInit   = 1'b1;
                w_stateNext = ST_DATA;
            end

            ST_DATA: begin
                if (r_byteVld) begin
                    w_txBit   = r_sreg[DATA_W-1];
                    w_txValid = 1'b1;
                    w_crcData = w_txBit;
                    if (bus.tx_ready) begin
                        w_crcEnable = 1'b1;
                        w_sregNext  = {r_sreg[DATA_W-2:0], 1'b0};
                        w_cntNext   = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            w_cntNext = '0;
                            if (r_lastFlag) begin
                                w_stateNext = ST_CRC_LOAD;
                            end else begin
                                w_sReady = 1'b1;
                                if (bus.s_valid) begin
                                    w_sregNext     = bus.s_data;
                                    w_lastFlagNext = bus.s_last;
                                end else begin
                                    w_byteVldNext = 1'b0;
                                end
                            end
                        end
                    end
                end else begin
                    w_sReady = 1'b1;
                    if (bus.s_valid) begin
                        w_sregNext     = bus.s_data;
                        w_lastFlagNext = bus.s_last;
                        w_cntNext      = '0;
                        w_byteVldNext  = 1'b1;
                    end
                end
            end

            ST_CRC_LOAD: begin
                w_crcSregNext = w_crcCapture;
                w_cntNext     = '0;
                w_stateNext   = ST_CRC;
            end

            ST_CRC: begin
                w_txBit   = r_crcSreg[CRC_W-1];
                w_txValid = 1'b1;
                w_txLast  = (r_cnt == CNT_W'(CRC_W - 1));
                if (bus.tx_ready) begin
                    w_crcSregNext = {r_crcSreg[CRC_W-2:0], 1'b0};
                    w_cntNext     = r_cnt + CNT_W'(1);
                    if (w_txLast) begin
                        w_cntNext   = '0;
                        w_stateNext = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                w_cntNext = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(IFG_CYCLES - 1)) begin
                    w_cntNext   = '0;
                    w_stateNext = ST_IDLE;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign bus.s_ready   = w_sReady & ~reset;
    assign bus.tx_bit    = w_txBit & ~reset;
    assign bus.tx_valid  = w_txValid & ~reset;
    assign bus.tx_last   = w_txLast & ~reset;
    assign o_crc_enable  = w_crcEnable & ~reset;
    assign o_crc_init    = w_crcInit & ~reset;
    assign o_crc_data    = w_crcData & ~reset;
    assign o_busy        = (r_state != ST_IDLE) & ~reset;
endmodule

// File: tb/tb_crc_frame_serializer.sv
// tb_crc_frame_serializer: directed bench for crc_frame_serializer. Two instances
// (gap of 2 and gap of 0) share the stimulus; each has its own serial CCITT engine.
module tb_crc_frame_serializer;
`ifdef CRC_FRAME_INVERT_EN
    localparam logic [15:0] EXP_00  = 16'h1E0F;
    localparam logic [15:0] EXP_STR = 16'hD64E;
`else
    localparam logic [15:0] EXP_00  = 16'hE1F0;
    localparam logic [15:0] EXP_STR = 16'h29B1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sData = '0;
    logic       sValid = 1'b0;
    logic       sLast = 1'b0;
    logic       txReady = 1'b1;
    logic       sel = 1'b0;

    logic        crcEnA, crcInitA, crcDataA, busyA;
    logic        crcEnB, crcInitB, crcDataB, busyB;
    logic [15:0] crcA, crcB;

    logic obsSReady, obsTxBit, obsTxValid, obsTxLast, obsEn, obsInit, obsData, obsBusy;

    int vectorsApplied = 0;
    int miscompares = 0;

    logic [7:0] frameBytes [0:15];
    logic       capBits [0:255];
    logic [7:0] lfsr = 8'hA5;
    int capN, bubbles, stableErr, enErr, zeroErr, stallCycles;
    int firstValidRel, lastRel, readyRel, initRel;
    bit timedOut;

    crc_frame_serializer_if #(.DATA_W(8)) ifA ();
    crc_frame_serializer_if #(.DATA_W(8)) ifB ();

    assign ifA.s_data   = sData;
    assign ifA.s_valid  = sValid;
    assign ifA.s_last   = sLast;
    assign ifA.tx_ready = txReady;
    assign ifB.s_data   = sData;
    assign ifB.s_valid  = sValid;
    assign ifB.s_last   = sLast;
    assign ifB.tx_ready = txReady;

    crc_frame_serializer #(.DATA_W(8), .CRC_W(16), .IFG_CYCLES(2)) dutA (
        .clk(clk), .reset(reset), .bus(ifA),
        .o_crc_enable(crcEnA), .o_crc_init(crcInitA), .o_crc_data(crcDataA),
        .i_crc_value(crcA), .o_busy(busyA)
    );

    crc_frame_serializer #(.DATA_W(8), .CRC_W(16), .IFG_CYCLES(0)) dutB (
        .clk(clk), .reset(reset), .bus(ifB),
        .o_crc_enable(crcEnB), .o_crc_init(crcInitB), .o_crc_data(crcDataB),
        .i_crc_value(crcB), .o_busy(busyB)
    );

    assign obsSReady  = sel ? ifB.s_ready  : ifA.s_ready;
    assign obsTxBit   = sel ? ifB.tx_bit   : ifA.tx_bit;
    assign obsTxValid = sel ? ifB.tx_valid : ifA.tx_valid;
    assign obsTxLast  = sel ? ifB.tx_last  : ifA.tx_last;
    assign obsEn      = sel ? crcEnB       : crcEnA;
    assign obsInit    = sel ? crcInitB     : crcInitA;
    assign obsData    = sel ? crcDataB     : crcDataA;
    assign obsBusy    = sel ? busyB        : busyA;

    always #5 clk = ~clk;

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic d);
        logic fb;
        fb = c[15] ^ d;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Serial CCITT engines (poly 0x1021, seed 0xFFFF, MSB-first) feeding each instance
    always @(posedge clk) begin
        if (reset) begin
            crcA <= 16'hFFFF;
            crcB <= 16'hFFFF;
        end else begin
            if (crcEnA) crcA <= crcInitA ? 16'hFFFF : crcStep(crcA, crcDataA);
            if (crcEnB) crcB <= crcInitB ? 16'hFFFF : crcStep(crcB, crcDataB);
        end
    end

    function automatic logic [15:0] capWord(input int start, input int width);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < width; k++) w = {w[14:0], capBits[start + k]};
        return w;
    endfunction

    // Drives one frame and records what appears on the link; judging is left to the callers
    task automatic runFrame(input int nBytes, input int stallAfter, input int stallLen, input bit randReady);
        int  idx = 0;
        int  stallCnt = 0;
        int  c = 0;
        int  acceptCycle = -1;
        int  rel;
        bit  stalling;
        bit  xfer;
        bit  prevStalled = 0;
        logic prevBit = 1'b0;
        logic prevLast = 1'b0;
        capN = 0; bubbles = 0; stableErr = 0; enErr = 0; zeroErr = 0; stallCycles = 0;
        firstValidRel = -1; lastRel = -1; readyRel = -1; initRel = -1; timedOut = 0;
        while (readyRel < 0 && !timedOut) begin
            @(negedge clk);
            stalling = (stallAfter >= 0) && (idx == stallAfter) && (stallCnt < stallLen);
            if (idx < nBytes && !stalling) begin
                sValid = 1'b1; sData = frameBytes[idx]; sLast = (idx == nBytes - 1);
            end else begin
                sValid = 1'b0; sData = '0; sLast = 1'b0;
            end
            if (randReady) begin
                txReady = lfsr[0];
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end else begin
                txReady = 1'b1;
            end
            #1;
            if (stalling && obsSReady) stallCnt++;
            if (sValid && obsSReady) begin
                if (acceptCycle < 0) acceptCycle = c;
                idx++;
            end
            rel = (acceptCycle < 0) ? -1 : c - acceptCycle;
            xfer = obsTxValid && txReady;
            if (obsTxValid && firstValidRel < 0) firstValidRel = rel;
            if (obsEn && obsInit && initRel < 0) initRel = rel;
            if (!obsTxValid && obsTxBit) zeroErr++;
            if (capN > 0 && capN < 8 * nBytes && !obsTxValid) bubbles++;
            if (prevStalled) begin
                stallCycles++;
                if (!obsTxValid || obsTxBit !== prevBit || obsTxLast !== prevLast) stableErr++;
            end
            if (obsEn && !obsInit && !(xfer && capN < 8 * nBytes && obsData === obsTxBit)) enErr++;
            if (xfer && capN < 8 * nBytes && !obsEn) enErr++;
            if (xfer) begin
                if (capN < 256) capBits[capN] = obsTxBit;
                capN++;
                if (obsTxLast && lastRel < 0) lastRel = rel;
            end else if (lastRel >= 0 && obsSReady) begin
                readyRel = rel;
            end
            prevStalled = obsTxValid && !txReady;
            prevBit = obsTxBit;
            prevLast = obsTxLast;
            c++;
            if (c > 3000) timedOut = 1;
        end
    endtask

    task automatic loadString();
        for (int i = 0; i < 9; i++) frameBytes[i] = 8'h31 + 8'(i);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        reset = 1'b1; sValid = 1'b1; sData = 8'hFF; sLast = 1'b1; txReady = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectorsApplied++;
        if ({obsSReady, obsTxBit, obsTxValid, obsTxLast, obsEn, obsInit, obsData, obsBusy} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b, expected 00000000",
                     {obsSReady, obsTxBit, obsTxValid, obsTxLast, obsEn, obsInit, obsData, obsBusy});
        end
        vectorsApplied++;
        if (ifB.s_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_sready_b: got %b, expected 0", ifB.s_ready);
        end
        @(negedge clk);
        reset = 1'b0; sValid = 1'b0; sData = '0; sLast = 1'b0;
        #1;
        vectorsApplied++;
        if ({obsSReady, obsTxValid, obsBusy} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %b, expected 100", {obsSReady, obsTxValid, obsBusy});
        end
    endtask

    task automatic test_single_byte();
        sel = 1'b0;
        frameBytes[0] = 8'h00;
        runFrame(1, -1, 0, 1'b0);
        vectorsApplied++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL single_timeout: got 1, expected 0"); end
        vectorsApplied++;
        if (capN != 24) begin miscompares++; $display("[TB] FAIL single_bits: got %0d, expected 24", capN); end
        vectorsApplied++;
        if (capWord(0, 8) !== 16'h0000) begin miscompares++; $display("[TB] FAIL single_data: got %h, expected 0000", capWord(0, 8)); end
        vectorsApplied++;
        if (capWord(8, 16) !== EXP_00) begin miscompares++; $display("[TB] FAIL single_crc: got %h, expected %h", capWord(8, 16), EXP_00); end
        vectorsApplied++;
        if (initRel != 1) begin miscompares++; $display("[TB] FAIL single_init_cycle: got %0d, expected 1", initRel); end
        vectorsApplied++;
        if (firstValidRel != 2) begin miscompares++; $display("[TB] FAIL single_first_bit: got %0d, expected 2", firstValidRel); end
        vectorsApplied++;
        if (lastRel != 26) begin miscompares++; $display("[TB] FAIL single_tx_last: got %0d, expected 26", lastRel); end
        vectorsApplied++;
        if (readyRel != 29) begin miscompares++; $display("[TB] FAIL single_sready_again: got %0d, expected 29", readyRel); end
        vectorsApplied++;
        if (enErr != 0 || zeroErr != 0) begin
            miscompares++;
            $display("[TB] FAIL single_enable: got %0d/%0d, expected 0/0", enErr, zeroErr);
        end
    endtask

    task automatic test_string();
        sel = 1'b0;
        loadString();
        runFrame(9, -1, 0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            vectorsApplied++;
            if (capWord(8 * i, 8) !== {8'h00, frameBytes[i]}) begin
                miscompares++;
                $display("[TB] FAIL string_byte%0d: got %h, expected %h", i, capWord(8 * i, 8), frameBytes[i]);
            end
        end
        vectorsApplied++;
        if (capWord(72, 16) !== EXP_STR) begin miscompares++; $display("[TB] FAIL string_crc: got %h, expected %h", capWord(72, 16), EXP_STR); end
        vectorsApplied++;
        if (bubbles != 0) begin miscompares++; $display("[TB] FAIL string_bubbles: got %0d, expected 0", bubbles); end
        vectorsApplied++;
        if (lastRel != 90) begin miscompares++; $display("[TB] FAIL string_tx_last: got %0d, expected 90", lastRel); end
        vectorsApplied++;
        if (readyRel != 93) begin miscompares++; $display("[TB] FAIL string_sready_again: got %0d, expected 93", readyRel); end
    endtask

    task automatic test_underrun();
        sel = 1'b0;
        loadString();
        runFrame(9, 4, 5, 1'b0);
        vectorsApplied++;
        if (bubbles != 5) begin miscompares++; $display("[TB] FAIL underrun_gap: got %0d, expected 5", bubbles); end
        vectorsApplied++;
        if (capWord(72, 16) !== EXP_STR) begin miscompares++; $display("[TB] FAIL underrun_crc: got %h, expected %h", capWord(72, 16), EXP_STR); end
        vectorsApplied++;
        if (capWord(32, 8) !== 16'h0035) begin miscompares++; $display("[TB] FAIL underrun_byte4: got %h, expected 0035", capWord(32, 8)); end
        vectorsApplied++;
        if (lastRel != 95) begin miscompares++; $display("[TB] FAIL underrun_tx_last: got %0d, expected 95", lastRel); end
        vectorsApplied++;
        if (enErr != 0 || zeroErr != 0) begin
            miscompares++;
            $display("[TB] FAIL underrun_enable: got %0d/%0d, expected 0/0", enErr, zeroErr);
        end
    endtask

    task automatic test_tx_stall();
        sel = 1'b0;
        loadString();
        runFrame(9, -1, 0, 1'b1);
        vectorsApplied++;
        if (timedOut || capN != 88) begin miscompares++; $display("[TB] FAIL stall_bits: got %0d, expected 88", capN); end
        for (int i = 0; i < 9; i++) begin
            vectorsApplied++;
            if (capWord(8 * i, 8) !== {8'h00, frameBytes[i]}) begin
                miscompares++;
                $display("[TB] FAIL stall_byte%0d: got %h, expected %h", i, capWord(8 * i, 8), frameBytes[i]);
            end
        end
        vectorsApplied++;
        if (capWord(72, 16) !== EXP_STR) begin miscompares++; $display("[TB] FAIL stall_crc: got %h, expected %h", capWord(72, 16), EXP_STR); end
        vectorsApplied++;
        if (stallCycles == 0 || stableErr != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold: got %0d unstable of %0d stalls, expected 0 of >0", stableErr, stallCycles);
        end
        vectorsApplied++;
        if (enErr != 0 || zeroErr != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_enable: got %0d/%0d, expected 0/0", enErr, zeroErr);
        end
    endtask

    task automatic test_reset_midframe();
        int  n = 0;
        int  budget = 0;
        bit  accepted = 0;
        sel = 1'b0;
        while (n < 11 && budget < 200) begin
            @(negedge clk);
            sValid = !accepted; sData = 8'h00; sLast = 1'b1; txReady = 1'b1;
            #1;
            if (sValid && obsSReady) accepted = 1;
            if (obsTxValid && txReady) n++;
            budget++;
        end
        vectorsApplied++;
        if (n != 11) begin miscompares++; $display("[TB] FAIL midreset_reach: got %0d bits, expected 11", n); end
        @(negedge clk);
        sValid = 1'b0; sLast = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        vectorsApplied++;
        if ({obsSReady, obsTxBit, obsTxValid, obsTxLast, obsEn, obsInit, obsData, obsBusy} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got %b, expected 00000000",
                     {obsSReady, obsTxBit, obsTxValid, obsTxLast, obsEn, obsInit, obsData, obsBusy});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectorsApplied++;
        if ({obsSReady, obsTxValid, obsBusy} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL midreset_idle: got %b, expected 100", {obsSReady, obsTxValid, obsBusy});
        end
        frameBytes[0] = 8'h00;
        runFrame(1, -1, 0, 1'b0);
        vectorsApplied++;
        if (capN != 24 || capWord(8, 16) !== EXP_00) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_crc: got %h (%0d bits), expected %h (24 bits)", capWord(8, 16), capN, EXP_00);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sel = 1'b1;
        loadString();
        runFrame(9, -1, 0, 1'b0);
        vectorsApplied++;
        if (capWord(72, 16) !== EXP_STR) begin miscompares++; $display("[TB] FAIL b2b_first_crc: got %h, expected %h", capWord(72, 16), EXP_STR); end
        vectorsApplied++;
        if (lastRel != 90 || readyRel != 91) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_ready: got last %0d ready %0d, expected 90 91", lastRel, readyRel);
        end
        frameBytes[0] = 8'h00;
        runFrame(1, -1, 0, 1'b0);
        vectorsApplied++;
        if (capWord(8, 16) !== EXP_00) begin miscompares++; $display("[TB] FAIL b2b_second_crc: got %h, expected %h", capWord(8, 16), EXP_00); end
        vectorsApplied++;
        if (initRel != 1) begin miscompares++; $display("[TB] FAIL b2b_second_init: got %0d, expected 1", initRel); end
        vectorsApplied++;
        if (lastRel != 26 || readyRel != 27) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_ready: got last %0d ready %0d, expected 26 27", lastRel, readyRel);
        end
    endtask

    // Watchdog so a wedged design still ends the run with a visible failure
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_single_byte();
        test_string();
        test_underrun();
        test_tx_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end
endmodule

// File: doc/crc_frame_serializer.md
Name: crc_frame_serializer

Overview:
- Transmit-side framing stage for the CCITT serial CRC engine (poly 0x1021, init 0xFFFF, MSB-first).
- Accepts a byte stream with valid/ready/last framing and serialises each frame MSB-first onto a bit link with a tx_ready handshake.
- Drives the CRC engine's enable/init/data_in inputs, then reads its 16-bit result and appends it to the frame, followed by an inter-frame gap.

Parameters:
DATA_W, 8, payload word width in bits
CRC_W, 16, CRC width in bits; must match the CRC engine
IFG_CYCLES, 2, idle cycles after the last CRC bit before the next frame is accepted; 0 means no gap

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_data  in  DATA_W  payload byte
s_valid  in  1  s_data valid
s_last  in  1  byte is the last of the frame; qualified by s_valid
s_ready  out  1  byte accepted when s_valid && s_ready
tx_bit  out  1  serial output bit
tx_valid  out  1  tx_bit valid
tx_ready  in  1  sink takes the bit when tx_valid && tx_ready
tx_last  out  1  high with the final CRC bit of a frame
crc_enable  out  1  to CRC engine enable
crc_init  out  1  to CRC engine init
crc_data  out  1  to CRC engine data_in
crc_value  in  CRC_W  from CRC engine crc_out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. Reset forces the state to IDLE and clears all registers. While reset is high, every output is 0, including s_ready. Reset asserted mid-frame aborts the frame immediately with no further tx bits. The CRC engine shares the same reset.
- States: IDLE, INIT, DATA, CRC_LOAD, CRC, GAP.
- IDLE:
  - s_ready=1, tx_valid=0.
  - On s_valid: load s_data into the byte shift register, latch s_last, clear bit_cnt, go to INIT.
- INIT (1 cycle):
  - crc_enable=1, crc_init=1, tx_valid=0, s_ready=0.
  - Go to DATA.
- DATA:
  - tx_bit=sreg[DATA_W-1]; tx_valid=byte_vld.
  - crc_data=tx_bit; crc_enable=tx_valid&&tx_ready; crc_init=0.
  - On each transfer: shift sreg left and increment bit_cnt.
  - On the transfer with bit_cnt==DATA_W-1:
    - last_flag set: go to CRC_LOAD.
    - Otherwise: s_ready=1 combinationally that cycle. If s_valid, load the new byte and continue back-to-back with no bubble. If not, clear byte_vld.
  - While byte_vld=0 (underrun): tx_valid=0, crc_enable=0, s_ready=1. Wait for s_valid, then load and resume. The CRC is unaffected by the stall.
  - s_ready=0 at all other times in DATA.
- CRC_LOAD (1 cycle):
  - tx_valid=0.
  - Capture crc_value, already updated by the last data edge, into crc_sreg.
  - Go to CRC.
- CRC:
  - tx_bit=crc_sreg[CRC_W-1]; tx_valid=1; crc_enable=0.
  - Shift on each transfer.
  - tx_last=1 when the CRC_W-th bit is presented.
  - After that bit transfers: go to GAP, or to IDLE if IFG_CYCLES==0.
- GAP:
  - tx_valid=0, s_ready=0.
  - Count IFG_CYCLES cycles, then go to IDLE.
- tx_ready low in any state:
  - Hold tx_bit and tx_last stable; crc_enable=0.
  - tx_ready has no effect in IDLE, INIT, CRC_LOAD or GAP.
- Throughput (tx_ready=1, no underrun): one frame of N bytes takes 1 + 1 + 8N + 1 + 16 + IFG_CYCLES cycles from acceptance to re-entry into IDLE. The 1s are the accept cycle, INIT and CRC_LOAD.
- s_last on a single-byte frame is valid; there is no zero-length frame.
- tx_bit is 0 whenever tx_valid=0.

Optional Feature:
- Macro: CRC_FRAME_INVERT_EN.
- Defined: CRC_LOAD captures ~crc_value, so the appended CRC is the ones-complement.
- Undefined: crc_value is appended unmodified.
- All other behaviour is identical in both cases.

Test Plan:
- Single byte 0x00, s_last=1, tx_ready=1, IFG_CYCLES=2:
  - Accept at cycle 0, INIT at cycle 1.
  - Data bits 00000000 on cycles 2-9.
  - CRC_LOAD at cycle 10; CRC bits 0xE1F0 MSB-first on cycles 11-26 (0x1E0F with CRC_FRAME_INVERT_EN).
  - tx_last at cycle 26; s_ready high again at cycle 29.
- Frame "123456789" (0x31..0x39), streamed back-to-back: 72 contiguous data bits with no bubbles, then appended CRC 0x29B1.
- Same frame with s_valid dropped for 5 cycles after byte 4: tx_valid low for 5 cycles, CRC still 0x29B1.
- tx_ready toggled pseudo-randomly through data and CRC: the bit sequence equals the unstalled one, tx_bit is stable while stalled, and crc_enable pulses only on transfers.
- Reset asserted at bit 3 of the CRC field: outputs go to 0 on the next edge. A following single-byte 0x00 frame yields 0xE1F0.
- Two back-to-back frames with IFG_CYCLES=0: s_ready is high in the cycle after tx_last, and the second frame's INIT re-seeds the CRC to 0xFFFF, so its CRC matches the standalone value.
